// File: rtl/rf_buffer_ctrl.sv
// Single-ported RF sample buffer shared by a CPU request/response port and a capture stream.
// The stream wins contention unless the CPU lost the previous cycle, which bounds the CPU wait to one cycle.
module rf_buffer_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  cap_start,
  input  logic                  cap_abort,
  input  logic [ADDR_WIDTH-1:0] cap_base,
  input  logic [ADDR_WIDTH:0]   cap_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic [ADDR_WIDTH:0]   cap_count
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [ADDR_WIDTH:0]     cap_count_q, cap_count_d;
  logic                    denied_q, denied_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_capture;
  logic                    stream_gnt;
  logic                    cpu_gnt;
  logic                    s_fire;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NB-1:0]           mem_be;

  assign in_capture = (state_q == ST_CAPTURE);

  // req_ready is masked while reset is held so nothing is accepted before the first IDLE cycle.
  always_comb begin
    stream_gnt  = in_capture && !(req_valid && denied_q);
    cpu_gnt     = !reset && req_valid && !(in_capture && s_valid && !denied_q);
    s_fire      = stream_gnt && s_valid;
    denied_d    = req_valid && !cpu_gnt;
    rsp_valid_d = cpu_gnt && !req_write;
    rsp_rdata_d = rsp_valid_d ? mem[req_addr] : rsp_rdata_q;
  end

  always_comb begin
    mem_we    = s_fire || (cpu_gnt && req_write);
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    mem_be    = req_be;
    if (s_fire) begin
      mem_addr  = wr_ptr_q;
      mem_wdata = s_data;
      mem_be    = '1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    cap_count_d = cap_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_start) begin
          wr_ptr_d    = cap_base;
          remaining_d = cap_len;
          cap_count_d = '0;
          state_d     = (cap_len == '0) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (s_fire) begin
          wr_ptr_d    = wr_ptr_q + PTR_ONE;
          remaining_d = remaining_q - CNT_ONE;
          cap_count_d = cap_count_q + CNT_ONE;
          if (remaining_q == CNT_ONE) state_d = ST_DONE;
        end
        // Abort overrides completion; a write accepted this cycle still counts.
        if (cap_abort) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      cap_count_q <= '0;
      denied_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      cap_count_q <= cap_count_d;
      denied_q    <= denied_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = cpu_gnt;
  assign s_ready   = stream_gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cap_busy  = in_capture;
  assign cap_done  = (state_q == ST_DONE);
  assign cap_count = cap_count_q;

endmodule

// File: tb/tb_rf_buffer_ctrl.sv
// Randomized and directed bench for rf_buffer_ctrl against a behavioural buffer/capture model.
module tb_rf_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        cap_start, cap_abort;
  logic [9:0]  cap_base;
  logic [10:0] cap_len;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        cap_busy, cap_done;
  logic [10:0] cap_count;

  int vectors = 0;
  int miscompares = 0;

  rf_buffer_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cap_start(cap_start), .cap_abort(cap_abort), .cap_base(cap_base), .cap_len(cap_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_count(cap_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: buffer image, capture window bookkeeping, CPU fairness flag.
  bit [31:0] m_mem [1024];
  int        m_mode;      // 0 idle, 1 capturing, 2 done
  int        m_ptr, m_left, m_count;
  bit        m_waited, m_rspv;
  bit [31:0] m_hold;
  bit        exp_req_ready, exp_s_ready;
  logic [1:0]  obs_pre, exp_pre;
  logic [45:0] obs_post, exp_post;

  task automatic mdl_reset;
    m_mode = 0; m_ptr = 0; m_left = 0; m_count = 0;
    m_waited = 0; m_rspv = 0; m_hold = 0;
  endtask

  task automatic mdl_predict;
    bit capturing;
    capturing     = (m_mode == 1);
    exp_s_ready   = capturing && !(req_valid && m_waited);
    exp_req_ready = req_valid && !(capturing && s_valid && !m_waited);
    exp_pre       = {exp_req_ready, exp_s_ready};
  endtask

  task automatic mdl_update;
    int old_mode;
    old_mode = m_mode;
    m_rspv = 0;
    if (exp_req_ready) begin
      if (req_write) begin
        for (int b = 0; b < 4; b++)
          if (req_be[b]) m_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
        m_rspv = 1;
        m_hold = m_mem[req_addr];
      end
    end
    m_waited = req_valid && !exp_req_ready;
    if (old_mode == 1) begin
      if (exp_s_ready && s_valid) begin
        m_mem[m_ptr] = s_data;
        m_ptr   = (m_ptr + 1) % 1024;
        m_count = m_count + 1;
        m_left  = m_left - 1;
      end
      if (cap_abort) m_mode = 0;
      else if (m_left == 0) m_mode = 2;
    end else if (old_mode == 2) begin
      m_mode = 0;
    end else if (cap_start) begin
      m_ptr = int'(cap_base); m_left = int'(cap_len); m_count = 0;
      m_mode = (cap_len == 0) ? 2 : 1;
    end
    exp_post = {m_rspv, m_hold, m_mode == 1, m_mode == 2, 11'(m_count)};
  endtask

  // One clock: inputs already driven after a falling edge; readies sampled before
  // the rising edge, registered outputs at the next falling edge.
  task automatic tick;
    #1;
    mdl_predict();
    obs_pre = {req_ready, s_ready};
    @(posedge clk);
    mdl_update();
    @(negedge clk);
    obs_post = {rsp_valid, rsp_rdata, cap_busy, cap_done, cap_count};
  endtask

  task automatic drive_idle;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_be = '0;
    cap_start = 0; cap_abort = 0; cap_base = '0; cap_len = '0;
    s_valid = 0; s_data = '0;
  endtask

  task automatic test_reset;
    drive_idle();
    reset = 1; req_valid = 1; s_valid = 1; cap_start = 1; cap_len = 11'd3;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({req_ready, s_ready, rsp_valid, rsp_rdata, cap_busy, cap_done, cap_count} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0",
               {req_ready, s_ready, rsp_valid, rsp_rdata, cap_busy, cap_done, cap_count});
    end
    @(negedge clk);
    drive_idle();
    reset = 0;
    mdl_reset();
    req_valid = 1; req_write = 1; req_be = 4'hF; req_wdata = $urandom;
    tick();
    vectors++;
    if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
      miscompares++;
      $display("FAIL first_cycle_after_reset: got %h want %h", {obs_pre, obs_post}, {exp_pre, exp_post});
    end
  endtask

  task automatic test_fill;
    drive_idle();
    for (int a = 0; a < 1024; a++) begin
      req_valid = 1; req_write = 1; req_be = 4'hF; req_addr = 10'(a); req_wdata = $urandom;
      tick();
      vectors++;
      if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        miscompares++;
        $display("FAIL fill @%0d: got %h want %h", a, {obs_pre, obs_post}, {exp_pre, exp_post});
      end
    end
    drive_idle();
  endtask

  task automatic test_byte_write;
    drive_idle();
    req_valid = 1; req_write = 1; req_addr = 10'h010; req_wdata = 32'hAABBCCDD; req_be = 4'hF;
    tick();
    req_wdata = 32'h11223344; req_be = 4'b0101;
    tick();
    req_write = 0; req_be = 4'h0;
    tick();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hAA22CC44) begin
      miscompares++;
      $display("FAIL byte_write_read: got v=%b %h want v=1 aa22cc44", rsp_valid, rsp_rdata);
    end
    for (int i = 0; i < 60; i++) begin
      req_valid = ($urandom_range(0, 3) != 0); req_write = $urandom_range(0, 1);
      req_addr = $urandom; req_wdata = $urandom; req_be = $urandom;
      tick();
      vectors++;
      if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        miscompares++;
        $display("FAIL cpu_random #%0d: got %h want %h", i, {obs_pre, obs_post}, {exp_pre, exp_post});
      end
    end
    drive_idle();
  endtask

  task automatic test_capture_wrap;
    drive_idle();
    cap_start = 1; cap_base = 10'h3FE; cap_len = 11'd4;
    tick();
    cap_start = 0;
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1; s_data = i;
      tick();
      vectors++;
      if (obs_pre[0] !== 1'b1 || {obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        miscompares++;
        $display("FAIL wrap_stream #%0d: got %h want %h", i, {obs_pre, obs_post}, {exp_pre, exp_post});
      end
    end
    vectors++;
    if ({cap_busy, cap_done, cap_count} !== {1'b0, 1'b1, 11'd4}) begin
      miscompares++;
      $display("FAIL wrap_done: got busy/done/count %b/%b/%0d want 0/1/4", cap_busy, cap_done, cap_count);
    end
    s_valid = 0;
    tick();
    vectors++;
    if (cap_done !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_done_width: got cap_done %b want 0", cap_done);
    end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_write = 0; req_addr = 10'h3FE + 10'(i);
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL wrap_readback @%h: got %h want %0d", req_addr, rsp_rdata, i + 1);
      end
    end
    drive_idle();
  endtask

  task automatic test_contention;
    logic [1:0] want_gnt;
    int wait_run;
    drive_idle();
    cap_start = 1; cap_base = $urandom; cap_len = 11'd10;
    tick();
    cap_start = 0;
    req_valid = 1; req_write = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom; req_be = 4'hF;
    s_valid = 1; s_data = $urandom;
    wait_run = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      want_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if (obs_pre !== want_gnt || {obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        miscompares++;
        $display("FAIL contention_grant k=%0d: got %h want %b/%h", k, {obs_pre, obs_post}, want_gnt, {exp_pre, exp_post});
      end
      if (obs_pre[1]) begin
        wait_run = 0;
        req_write = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
      end else begin
        wait_run++;
      end
      vectors++;
      if (wait_run > 1) begin
        miscompares++;
        $display("FAIL cpu_wait k=%0d: got %0d cycles want <=1", k, wait_run);
      end
      if (obs_pre[0]) s_data = $urandom;
    end
    drive_idle();
    tick();
  endtask

  task automatic test_zero_len_and_ignored_start;
    logic [9:0] base;
    drive_idle();
    cap_start = 1; cap_base = $urandom; cap_len = 11'd0;
    tick();
    cap_start = 0;
    vectors++;
    if ({cap_busy, cap_done, cap_count} !== {1'b0, 1'b1, 11'd0} || obs_post !== exp_post) begin
      miscompares++;
      $display("FAIL zero_len_done: got %h want %h", obs_post, exp_post);
    end
    req_valid = 1; req_addr = cap_base;
    tick();
    vectors++;
    if (cap_done !== 1'b0 || obs_post !== exp_post) begin
      miscompares++;
      $display("FAIL zero_len_nowrite: got %h want %h", obs_post, exp_post);
    end
    drive_idle();
    base = $urandom;
    cap_start = 1; cap_base = base; cap_len = 11'd3;
    tick();
    for (int i = 0; i < 3; i++) begin
      cap_start = (i == 0); cap_base = base + 10'd100; cap_len = 11'd7;
      s_valid = 1; s_data = $urandom;
      tick();
      vectors++;
      if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        miscompares++;
        $display("FAIL ignored_start #%0d: got %h want %h", i, {obs_pre, obs_post}, {exp_pre, exp_post});
      end
    end
    vectors++;
    if ({cap_done, cap_count} !== {1'b1, 11'd3}) begin
      miscompares++;
      $display("FAIL ignored_start_done: got done/count %b/%0d want 1/3", cap_done, cap_count);
    end
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_addr = base + 10'(i);
      tick();
      vectors++;
      if (obs_post !== exp_post) begin
        miscompares++;
        $display("FAIL ignored_start_readback #%0d: got %h want %h", i, obs_post, exp_post);
      end
    end
    drive_idle();
  endtask

  task automatic test_abort;
    drive_idle();
    cap_start = 1; cap_base = $urandom; cap_len = 11'd8;
    tick();
    cap_start = 0;
    repeat (3) begin s_valid = 1; s_data = $urandom; tick(); end
    s_valid = 0; cap_abort = 1;
    tick();
    cap_abort = 0;
    vectors++;
    if ({cap_busy, cap_done, cap_count} !== {1'b0, 1'b0, 11'd3}) begin
      miscompares++;
      $display("FAIL abort_state: got busy/done/count %b/%b/%0d want 0/0/3", cap_busy, cap_done, cap_count);
    end
    s_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_pre[0] !== 1'b0 || {obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        miscompares++;
        $display("FAIL abort_after #%0d: got %h want %h", i, {obs_pre, obs_post}, {exp_pre, exp_post});
      end
    end
    drive_idle();
    cap_start = 1; cap_base = $urandom; cap_len = 11'd2;
    tick();
    cap_start = 0; s_valid = 1; s_data = $urandom;
    tick();
    s_data = $urandom; cap_abort = 1;
    tick();
    vectors++;
    if ({cap_busy, cap_done, cap_count} !== {1'b0, 1'b0, 11'd2} || obs_post !== exp_post) begin
      miscompares++;
      $display("FAIL abort_last_write: got %h want done 0 count 2 (%h)", obs_post, exp_post);
    end
    drive_idle();
    tick();
    vectors++;
    if (cap_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got cap_done %b want 0", cap_done);
    end
  endtask

  task automatic test_random;
    drive_idle();
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 1) == 1); req_write = $urandom_range(0, 1);
      req_addr = $urandom; req_wdata = $urandom; req_be = $urandom;
      s_valid = ($urandom_range(0, 9) < 7); s_data = $urandom;
      cap_start = ($urandom_range(0, 9) == 0); cap_base = $urandom;
      cap_len = 11'($urandom_range(0, 12));
      cap_abort = ($urandom_range(0, 29) == 0);
      tick();
      vectors++;
      if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        miscompares++;
        $display("FAIL random #%0d: got %h want %h", i, {obs_pre, obs_post}, {exp_pre, exp_post});
      end
    end
    drive_idle();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_capture;
    logic [9:0] base;
    drive_idle();
    base = $urandom;
    cap_start = 1; cap_base = base; cap_len = 11'd8;
    tick();
    cap_start = 0; s_valid = 1; s_data = $urandom;
    tick();
    s_valid = 0; req_valid = 1; req_write = 0; req_addr = base;
    #1;
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    vectors++;
    if ({req_ready, s_ready, rsp_valid, rsp_rdata, cap_busy, cap_done, cap_count} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_mid_capture: got %h want 0",
               {req_ready, s_ready, rsp_valid, rsp_rdata, cap_busy, cap_done, cap_count});
    end
    mdl_reset();
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 0;
    tick();
    vectors++;
    if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", {obs_pre, obs_post}, {exp_pre, exp_post});
    end
    req_valid = 1; req_addr = base;
    tick();
    vectors++;
    if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
      miscompares++;
      $display("FAIL reset_retains_mem: got %h want %h", {obs_pre, obs_post}, {exp_pre, exp_post});
    end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    drive_idle();
    mdl_reset();
    test_reset();
    test_fill();
    test_byte_write();
    test_capture_wrap();
    test_contention();
    test_zero_len_and_ignored_start();
    test_abort();
    test_random();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_buffer_ctrl.md
# rf_buffer_ctrl

Parametrised, single-ported RF sample buffer with two clients: a CPU request/response port (byte-enabled reads/writes, one-cycle read latency) and a streaming capture port. The capture port fills a programmable window of the buffer from the RF front end under a small capture state machine. It sits between the RISC-V core's load/store path and the RF sample stream, and arbitrates both clients onto one memory port with anti-starvation.

## Interface
- ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  CPU request accepted this cycle when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  CPU word address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  NB  byte enables; bit i covers bits 8i+7:8i
- rsp_valid  out  1  read data valid, one-cycle pulse
- rsp_rdata  out  DATA_WIDTH  read data; holds last value
- cap_start  in  1  start-capture pulse, honoured only in IDLE
- cap_abort  in  1  abort capture, returns to IDLE
- cap_base  in  ADDR_WIDTH  first capture address, sampled on accepted cap_start
- cap_len  in  ADDR_WIDTH+1  words to capture, sampled on accepted cap_start
- s_valid  in  1  stream sample present
- s_ready  out  1  stream sample accepted when high with s_valid
- s_data  in  DATA_WIDTH  stream sample
- cap_busy  out  1  high in CAPTURE
- cap_done  out  1  one-cycle pulse on capture completion
- cap_count  out  ADDR_WIDTH+1  words written in current/last capture

## Operation
- States: IDLE, CAPTURE, DONE. Reset -> IDLE.
- IDLE: cap_start -> latch wr_ptr = cap_base, remaining = cap_len, cap_count = 0; cap_len = 0 -> DONE, else -> CAPTURE.
- CAPTURE: each accepted sample writes s_data (all bytes) at wr_ptr, wr_ptr = wr_ptr+1 mod depth (wraps 2**ADDR_WIDTH-1 -> 0), cap_count+1; last word (remaining = 1) -> DONE. cap_abort -> IDLE, no cap_done, cap_count keeps words written, including a write accepted in the abort cycle. cap_start ignored.
- DONE: cap_done = 1 for exactly one cycle -> IDLE.
- s_ready is 0 outside CAPTURE; samples are not consumed.
- Arbitration (one memory access/cycle): in CAPTURE with s_valid and req_valid both high, the stream wins unless the CPU was denied in the previous cycle; then the CPU wins and s_ready = 0. The CPU therefore never waits more than one cycle. Without contention each client is granted immediately.
- s_ready and req_ready are combinational from state, s_valid, req_valid and the denied flag.
- CPU write: only lanes with req_be[i] = 1 update; req_be = 0 is accepted and is a no-op.
- CPU read: rdata is registered to rsp_rdata, and rsp_valid pulses the next cycle. Back-to-back reads give one response per cycle.
- Memory contents are not reset.

## Timing
- Reset values: req_ready 0, s_ready 0, rsp_valid 0, rsp_rdata 0, cap_busy 0, cap_done 0, cap_count 0, state IDLE, denied flag 0.
- The first cycle after reset deassertion is IDLE; req_ready follows req_valid from then on.
- Read latency is 1 cycle from accept to rsp_valid.
- A CPU read issued the cycle after a stream write to the same address returns the new data.
- cap_start to first possible s_ready: 1 cycle.
- The last write is in cycle N; cap_done is in cycle N+1; cap_busy falls in cycle N+1.
- cap_abort and final write in the same cycle: the write happens, abort wins, and cap_done does not pulse.
- Asynchronous reset mid-capture: all outputs return to their reset values immediately. Words already written stay in memory.

## Test plan
- Reset: assert reset mid-CAPTURE with a pending read -> all outputs 0 asynchronously, state IDLE, rsp_valid does not pulse after release.
- CPU byte write: write 0xAABBCCDD @0x010 be=4'hF, then 0x11223344 be=4'b0101, then read @0x010 -> rsp_rdata 0xAA22CC44 one cycle after accept.
- Capture with wrap: cap_base=0x3FE, cap_len=4, stream 1,2,3,4 continuous -> words at 0x3FE,0x3FF,0x000,0x001; cap_done pulses once the cycle after the 4th write, cap_count=4.
- Contention: during capture, continuous s_valid plus req_valid -> grants alternate stream/CPU/stream/CPU, and no CPU wait exceeds 1 cycle.
- Zero-length and ignored start: cap_len=0 -> cap_done the cycle after the IDLE->DONE transition, no writes. cap_start during CAPTURE has no effect on wr_ptr/remaining.
- Abort: cap_len=8, abort after 3 samples -> IDLE, cap_count=3, no cap_done, s_ready=0 thereafter.
